// File: rtl/seq_loader_pkg.sv
// Shared opcodes, frame geometry, FSM states and error codes for the sequence loader.
package seq_loader_pkg;
  localparam logic [7:0] CMD_WRITE   = 8'h77;
  localparam logic [7:0] CMD_RUN     = 8'h72;
  localparam int         HDR_BYTES   = 10;
  localparam int         ENTRY_BYTES = 6;

  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CSUM} state_t;
endpackage

// File: rtl/seq_loader_byte_timeout.sv
// Inter-byte idle counter; expire fires on the cycle the count reaches TIMEOUT_CYC-1.
module seq_byte_timeout #(
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic CLK,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // A clear in the expiry cycle suppresses expire, so a late byte still wins.
  assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seq_loader.sv
// UART frame parser: 'w' uploads header + 48-bit entries + XOR checksum into BRAM
// and commits loop config; 'r' requests a run.
module seq_loader
  import seq_loader_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 48,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [15:0]       seq_len,
  output logic [7:0]        lstr,
  output logic [7:0]        lend,
  output logic [7:0]        llen,
  output logic [15:0]       lnum,
  output logic [7:0]        lstr2,
  output logic [7:0]        lend2,
  output logic [7:0]        llen2,
  output logic [15:0]       lnum2,
  output logic              cfg_valid,
  output logic              run_req,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int DEPTH = 1 << ADDR_W;

  state_t              state, state_nx;
  logic [3:0]          hdr_cnt;
  logic [2:0]          byte_cnt;
  logic [ADDR_W-1:0]   ent_idx;
  logic [79:0]         hdr_sr;
  logic [DATA_W-9:0]   asm_sr;
  logic [7:0]          xor_acc;
  logic                tmo_expire;

  logic                do_start, do_run, do_write, do_commit, set_err;
  logic [1:0]          set_code;

  // Header shadow: the fields sit in the shift register in arrival order.
  logic [79:0] hdr_nx;
  logic [15:0] sh_len, sh_lnum, sh_lnum2, len_in;
  logic [7:0]  sh_lstr, sh_lend, sh_lstr2, sh_lend2;
  assign hdr_nx   = {hdr_sr[71:0], rx_data};
  assign len_in   = hdr_nx[79:64];
  assign sh_len   = hdr_sr[79:64];
  assign sh_lstr  = hdr_sr[63:56];
  assign sh_lend  = hdr_sr[55:48];
  assign sh_lnum  = hdr_sr[47:32];
  assign sh_lstr2 = hdr_sr[31:24];
  assign sh_lend2 = hdr_sr[23:16];
  assign sh_lnum2 = hdr_sr[15:0];

  assign busy = (state != ST_IDLE);

  seq_byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .CLK    (CLK),
    .rst    (rst),
    .clr    (rx_valid || (state == ST_IDLE)),
    .en     (state != ST_IDLE),
    .expire (tmo_expire)
  );

  always_ff @(posedge CLK) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_start  = 1'b0;
    do_run    = 1'b0;
    do_write  = 1'b0;
    do_commit = 1'b0;
    set_err   = 1'b0;
    set_code  = 2'd0;
    if (rx_valid) begin
      unique case (state)
        ST_IDLE: begin
          if (rx_data == CMD_WRITE) begin
            do_start = 1'b1;
            state_nx = ST_HDR;
          end else if (rx_data == CMD_RUN) begin
            do_run = 1'b1;
          end
        end
        ST_HDR: begin
          if (hdr_cnt == 4'(HDR_BYTES - 1)) begin
            if (int'(len_in) > DEPTH) begin
              set_err  = 1'b1;
              set_code = ERR_LEN;
              state_nx = ST_IDLE;
            end else if (len_in == 16'd0) begin
              state_nx = ST_CSUM;
            end else begin
              state_nx = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_cnt == 3'(ENTRY_BYTES - 1)) begin
            do_write = 1'b1;
            if (int'(ent_idx) == int'(sh_len) - 1) state_nx = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (((rx_data ^ xor_acc) != 8'd0) || (sh_lend < sh_lstr) || (sh_lend2 < sh_lstr2)) begin
            set_err  = 1'b1;
            set_code = ERR_CSUM;
          end else begin
            do_commit = 1'b1;
          end
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (tmo_expire) begin
      set_err  = 1'b1;
      set_code = ERR_TIMEOUT;
      state_nx = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0;
      seq_len <= '0; lstr <= '0; lend <= '0; llen <= '0; lnum <= '0;
      lstr2 <= '0; lend2 <= '0; llen2 <= '0; lnum2 <= '0;
      cfg_valid <= 1'b0; run_req <= 1'b0; err <= 1'b0; err_code <= '0;
      hdr_cnt <= '0; byte_cnt <= '0; ent_idx <= '0; hdr_sr <= '0; asm_sr <= '0; xor_acc <= '0;
    end else begin
      wr_en     <= do_write;
      cfg_valid <= do_commit;
      run_req   <= do_run;
      if (do_start) begin
        err <= 1'b0; err_code <= '0; hdr_cnt <= '0; xor_acc <= '0;
      end
      if (set_err) begin
        err <= 1'b1; err_code <= set_code;
      end
      if (rx_valid && state != ST_IDLE) xor_acc <= xor_acc ^ rx_data;
      if (rx_valid && state == ST_HDR) begin
        hdr_sr   <= hdr_nx;
        hdr_cnt  <= hdr_cnt + 1'b1;
        ent_idx  <= '0;
        byte_cnt <= '0;
        wr_addr  <= '0;
      end
      if (rx_valid && state == ST_DATA) begin
        asm_sr   <= {asm_sr[DATA_W-17:0], rx_data};
        byte_cnt <= (byte_cnt == 3'(ENTRY_BYTES - 1)) ? 3'd0 : byte_cnt + 1'b1;
      end
      if (do_write) begin
        wr_addr <= ent_idx;
        wr_data <= {asm_sr, rx_data};
        ent_idx <= ent_idx + 1'b1;
      end
      if (do_commit) begin
        seq_len <= sh_len;
        lstr  <= sh_lstr;  lend  <= sh_lend;  llen  <= sh_lend - sh_lstr;   lnum  <= sh_lnum;
        lstr2 <= sh_lstr2; lend2 <= sh_lend2; llen2 <= sh_lend2 - sh_lstr2; lnum2 <= sh_lnum2;
      end
    end
  end
endmodule

// File: tb/tb_seq_loader.sv
// Frame-level scoreboard bench for seq_loader: expected events queued per frame, monitor compares.
module tb_seq_loader;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 48;
  localparam int TMO    = 100;
  localparam int DEPTH  = 1 << ADDR_W;

  logic CLK = 1'b0, rst = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic wr_en, cfg_valid, run_req, busy, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [15:0] seq_len, lnum, lnum2;
  logic [7:0]  lstr, lend, llen, lstr2, lend2, llen2;
  logic [1:0]  err_code;

  always #5 CLK = ~CLK;

  seq_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_len(seq_len), .lstr(lstr), .lend(lend), .llen(llen), .lnum(lnum),
    .lstr2(lstr2), .lend2(lend2), .llen2(llen2), .lnum2(lnum2),
    .cfg_valid(cfg_valid), .run_req(run_req), .busy(busy), .err(err), .err_code(err_code)
  );

  typedef struct { int kind; logic [127:0] pl; } ev_t;  // kind: 0 write, 1 cfg, 2 run, 3 err
  ev_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  logic [95:0] m_cfg = '0;
  logic m_err = 1'b0;
  logic [1:0] m_code = 2'd0;
  logic last_rxv = 1'b0, err_q = 1'b0;
  logic [95:0] cfg_now;
  assign cfg_now = {seq_len, lstr, lend, llen, lnum, lstr2, lend2, llen2, lnum2};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [127:0] p);
    ev_t e;
    e.kind = k; e.pl = p;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [127:0] p, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: unexpected event payload %0h, none expected", nm, p);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, 128'(k), 128'(e.kind));
      chk(nm, p, e.pl);
    end
    if (!(k == 3 && p == 128'd1)) chk({nm, "_latency"}, 128'(last_rxv), 128'd1);
  endtask

  always @(posedge CLK) last_rxv <= rx_valid;

  always @(negedge CLK) begin
    if (wr_en)        observe(0, 128'({16'(wr_addr), wr_data}), "write");
    if (cfg_valid)    observe(1, 128'(cfg_now), "cfg");
    if (run_req)      observe(2, 128'd0, "run");
    if (err && !err_q) observe(3, 128'(err_code), "err");
    err_q = err;
  end

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic checkpoint(input string nm);
    chk({nm, "_busy"}, 128'(busy), 128'd0);
    chk({nm, "_err"}, 128'({err, err_code}), 128'({m_err, m_code}));
    chk({nm, "_cfg"}, 128'(cfg_now), 128'(m_cfg));
  endtask

  // Builds the byte stream of one upload frame and queues its expected outcome.
  task automatic run_frame(input string nm, input logic [15:0] len, input logic [7:0] ls, input logic [7:0] le,
                           input logic [15:0] ln, input logic [7:0] ls2, input logic [7:0] le2,
                           input logic [15:0] ln2, input logic [47:0] ents[$], input logic [7:0] flip,
                           input int gapmax);
    logic [7:0] b[$];
    logic [7:0] cs;
    logic [95:0] cfg;
    b = '{len[15:8], len[7:0], ls, le, ln[15:8], ln[7:0], ls2, le2, ln2[15:8], ln2[7:0]};
    m_err = 1'b0; m_code = 2'd0;
    if (int'(len) > DEPTH) begin
      expect_ev(3, 128'd2);
      m_err = 1'b1; m_code = 2'd2;
    end else begin
      foreach (ents[i]) begin
        expect_ev(0, 128'({16'(i), ents[i]}));
        for (int j = 5; j >= 0; j--) b.push_back(ents[i][j*8 +: 8]);
      end
      cs = 8'h00;
      foreach (b[i]) cs = cs ^ b[i];
      b.push_back(cs ^ flip);
      if (flip != 8'h00 || le < ls || le2 < ls2) begin
        expect_ev(3, 128'd3);
        m_err = 1'b1; m_code = 2'd3;
      end else begin
        cfg = {len, ls, le, 8'(le - ls), ln, ls2, le2, 8'(le2 - ls2), ln2};
        expect_ev(1, 128'(cfg));
        m_cfg = cfg;
      end
    end
    send(8'h77, $urandom_range(gapmax));
    foreach (b[i]) send(b[i], $urandom_range(gapmax));
    repeat (3) @(negedge CLK);
    checkpoint(nm);
  endtask

  initial begin
    logic [47:0] ents[$];
    logic [7:0] ls, le, ls2, le2;
    int len;
    @(negedge CLK);
    repeat (2) @(negedge CLK);
    chk("reset_cfg", 128'(cfg_now), 128'd0);
    chk("reset_misc", 128'({wr_en, wr_addr, wr_data, cfg_valid, run_req, busy, err, err_code}), 128'd0);
    rst = 1'b1;
    @(negedge CLK);

    ents = '{48'hAAAAAAAAAAAA, 48'h555555555555};
    run_frame("good", 16'd2, 8'd0, 8'd1, 16'd3, 8'd0, 8'd0, 16'd0, ents, 8'h00, 2);
    run_frame("bad_csum", 16'd2, 8'd0, 8'd1, 16'd3, 8'd0, 8'd0, 16'd0, ents, 8'h01, 1);
    expect_ev(2, 128'd0);
    send(8'h72, 2);
    send(8'h10, 2);
    checkpoint("run_idle");
    ents = '{};
    run_frame("len_over", 16'h1001, 8'd0, 8'd1, 16'd3, 8'd0, 8'd0, 16'd0, ents, 8'h00, 1);
    ents = '{48'h727272727272};
    run_frame("run_as_data", 16'd1, 8'd2, 8'd7, 16'd9, 8'd1, 8'd3, 16'd4, ents, 8'h00, 0);
    ents = '{};
    run_frame("len_zero", 16'd0, 8'd4, 8'd4, 16'd1, 8'd0, 8'd255, 16'hFFFF, ents, 8'h00, 1);
    ents = '{48'h123456789ABC};
    run_frame("bad_bounds", 16'd1, 8'd5, 8'd4, 16'd1, 8'd0, 8'd1, 16'd1, ents, 8'h00, 1);

    // Timeout after 3 entry bytes: err must appear exactly TMO cycles after the last byte.
    send(8'h77, 0);
    foreach (ents[i]) begin end
    send(8'h00, 0); send(8'h02, 0);
    repeat (8) send(8'h01, 0);
    repeat (3) send(8'hEE, 0);
    expect_ev(3, 128'd1);
    repeat (TMO - 1) @(negedge CLK);
    chk("tmo_early", 128'({err, busy}), 128'({1'b0, 1'b1}));
    @(negedge CLK);
    chk("tmo_fire", 128'({err, err_code, busy}), 128'({1'b1, 2'd1, 1'b0}));
    m_err = 1'b1; m_code = 2'd1;
    checkpoint("tmo_after");
    ents = '{48'h0102030405FF};
    run_frame("after_tmo", 16'd1, 8'd1, 8'd9, 16'd2, 8'd3, 8'd3, 16'd5, ents, 8'h00, 1);

    // Reset in DATA: one entry written, then the frame is discarded.
    send(8'h77, 0);
    send(8'h00, 0); send(8'h03, 0);
    repeat (8) send(8'h00, 0);
    expect_ev(0, 128'({16'd0, 48'hC0FFEE112233}));
    for (int j = 5; j >= 0; j--) begin
      logic [47:0] w;
      w = 48'hC0FFEE112233;
      send(w[j*8 +: 8], 0);
    end
    send(8'h44, 0); send(8'h55, 0);
    rst = 1'b0;
    @(negedge CLK);
    chk("rst_cfg", 128'(cfg_now), 128'd0);
    chk("rst_misc", 128'({wr_en, wr_addr, wr_data, cfg_valid, run_req, busy, err, err_code}), 128'd0);
    rst = 1'b1;
    m_cfg = '0; m_err = 1'b0; m_code = 2'd0;
    ents = '{48'hDEADBEEF0001, 48'h0000FFFF7777, 48'h777777777777};
    run_frame("b2b", 16'd3, 8'd0, 8'd2, 16'd10, 8'd1, 8'd2, 16'd20, ents, 8'h00, 0);

    for (int it = 0; it < 30; it++) begin
      int op;
      op = $urandom_range(0, 4);
      if (op <= 2) begin
        len = $urandom_range(0, 4);
        ents = '{};
        for (int i = 0; i < len; i++) ents.push_back({$urandom(), 16'($urandom())});
        ls = 8'($urandom); le = 8'($urandom_range(int'(ls), 255));
        ls2 = 8'($urandom_range(1, 255)); le2 = 8'($urandom_range(int'(ls2), 255));
        if (op == 2) le2 = 8'($urandom_range(0, int'(ls2) - 1));
        run_frame("rnd", 16'(len), ls, le, 16'($urandom), ls2, le2, 16'($urandom), ents,
                  (op == 1) ? 8'($urandom_range(1, 255)) : 8'h00, 3);
      end else if (op == 3) begin
        expect_ev(2, 128'd0);
        send(8'h72, $urandom_range(0, 3));
      end else begin
        send(8'($urandom_range(0, 8'h71)), $urandom_range(0, 3));
      end
    end

    repeat (5) @(negedge CLK);
    checkpoint("final");
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
